// File: rtl/sram_spi_pkg.sv
// Shared constants and state encoding for the SPI SRAM read-capture path.
package sram_spi_pkg;

  localparam logic [7:0] SRAM_INST_READ  = 8'h03;
  localparam logic [7:0] SRAM_INST_WRITE = 8'h02;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_SKIP,
    RX_CAPTURE
  } rx_state_t;

endpackage

// File: rtl/sram_rx_fifo.sv
// Synchronous first-word-fall-through byte FIFO with a registered head word.
// Pointers carry an extra MSB so that count = wr - rd distinguishes full from empty.
module sram_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [AW:0]      wr_ptr_d, rd_ptr_d;
  logic [WIDTH-1:0] head_q;
  logic             push_ok, pop_ok;

  assign count_o  = wr_ptr_q - rd_ptr_q;
  assign full_o   = count_o[AW];
  assign empty_o  = (count_o == '0);
  assign pop_ok   = pop_i & ~empty_o;
  // A push into a full FIFO is only legal when the same edge frees a slot.
  assign push_ok  = push_i & (~full_o | pop_ok);
  assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_ok};
  assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop_ok};
  assign rd_data_o = head_q;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end
  end

  // Head is a registered read of the next read address, bypassing a same-edge write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (wr_ptr_d != rd_ptr_d) begin
        if (push_ok && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0])) begin
          head_q <= wr_data_i;
        end else begin
          head_q <= mem_q[rd_ptr_d[AW-1:0]];
        end
      end
    end
  end

endmodule

// File: rtl/sram_spi_read_capture.sv
// Captures MISO during READ data phases, packs bytes MSB-first into a FIFO stream.
// Optional SRAM_RX_CHECKSUM_EN adds rx_checksum: XOR of all bytes completed in the current read.
module sram_spi_read_capture
  import sram_spi_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int SKIP_BITS = 1
) (
  input  logic                     sclk,
  input  logic                     rst_n,
  input  logic                     miso,
  input  logic                     io_valid,
  input  logic                     rw_done,
  input  logic                     rd_sel,
  output logic [7:0]               m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  input  logic                     ovf_clr,
`ifdef SRAM_RX_CHECKSUM_EN
  output logic [7:0]               rx_checksum,
`endif
  output logic                     partial
);

  rx_state_t  state_q;
  logic [7:0] skip_cnt_q;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic [6:0] shreg_q;
  logic       partial_q, overflow_q;
  logic       start, byte_push, pop, drop, fifo_full, fifo_empty;
  logic [7:0] rx_byte;

  assign start     = (state_q == RX_IDLE) & io_valid & rd_sel;
  assign byte_push = (state_q == RX_CAPTURE) & io_valid & (bitcnt_q == 3'd7);
  assign rx_byte   = {shreg_q, miso};
  assign bitcnt_d  = bitcnt_q + {2'b00, io_valid};
  assign m_valid   = ~fifo_empty;
  assign pop       = m_valid & m_ready;
  assign drop      = byte_push & fifo_full & ~pop;
  assign partial   = partial_q;
  assign overflow  = overflow_q;

`ifdef SRAM_RX_CHECKSUM_EN
  logic [7:0] checksum_q;
  assign rx_checksum = checksum_q;
`endif

  always_ff @(posedge sclk) begin
    if (!rst_n) begin
      state_q    <= RX_IDLE;
      skip_cnt_q <= '0;
      bitcnt_q   <= '0;
      shreg_q    <= '0;
      partial_q  <= 1'b0;
      overflow_q <= 1'b0;
`ifdef SRAM_RX_CHECKSUM_EN
      checksum_q <= '0;
`endif
    end else begin
      // A new overflow outranks a simultaneous clear.
      if (drop) overflow_q <= 1'b1;
      else if (ovf_clr) overflow_q <= 1'b0;
`ifdef SRAM_RX_CHECKSUM_EN
      if (start) checksum_q <= '0;
      else if (byte_push) checksum_q <= checksum_q ^ rx_byte;
`endif
      unique case (state_q)
        RX_IDLE: begin
          if (start) begin
            partial_q  <= 1'b0;
            bitcnt_q   <= '0;
            skip_cnt_q <= 8'd1;
            if (SKIP_BITS == 0) begin
              shreg_q  <= {shreg_q[5:0], miso};
              bitcnt_q <= 3'd1;
              state_q  <= RX_CAPTURE;
            end else if (SKIP_BITS == 1) begin
              state_q <= RX_CAPTURE;
            end else begin
              state_q <= RX_SKIP;
            end
          end
        end
        RX_SKIP: begin
          if (rw_done || !io_valid) begin
            state_q <= RX_IDLE;
          end else begin
            skip_cnt_q <= skip_cnt_q + 8'd1;
            if (skip_cnt_q + 8'd1 == 8'(SKIP_BITS)) state_q <= RX_CAPTURE;
          end
        end
        RX_CAPTURE: begin
          if (io_valid) begin
            shreg_q  <= {shreg_q[5:0], miso};
            bitcnt_q <= bitcnt_d;
          end
          if (rw_done || !io_valid) begin
            state_q   <= RX_IDLE;
            partial_q <= (bitcnt_d != 3'd0);
          end
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

  sram_rx_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (sclk),
    .rst_n     (rst_n),
    .push_i    (byte_push),
    .wr_data_i (rx_byte),
    .pop_i     (pop),
    .rd_data_o (m_data),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

endmodule

// File: tb/tb_sram_spi_read_capture.sv
// Scoreboard bench: a queue models FIFO contents; bytes are pushed when their 8th bit is driven.
module tb_sram_spi_read_capture;

  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          sclk = 1'b0;
  logic          rst_n = 1'b0;
  logic          miso = 1'b0;
  logic          io_valid = 1'b0;
  logic          rw_done = 1'b0;
  logic          rd_sel = 1'b0;
  logic [7:0]    m_data;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [CW-1:0] fifo_count;
  logic          overflow;
  logic          ovf_clr = 1'b0;
  logic          partial;
`ifdef SRAM_RX_CHECKSUM_EN
  logic [7:0]    rx_checksum;
`endif

  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_q[$];
  logic [7:0] tx_bytes[$];
  logic       exp_ovf = 1'b0;

  always #5 sclk = ~sclk;

  sram_spi_read_capture #(.DEPTH(DEPTH), .SKIP_BITS(1)) dut (
    .sclk       (sclk),
    .rst_n      (rst_n),
    .miso       (miso),
    .io_valid   (io_valid),
    .rw_done    (rw_done),
    .rd_sel     (rd_sel),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .ovf_clr    (ovf_clr),
`ifdef SRAM_RX_CHECKSUM_EN
    .rx_checksum(rx_checksum),
`endif
    .partial    (partial)
  );

  // One bit-clock cycle: check stream outputs against the model, then apply the edge.
  task automatic step(input logic iv, input logic md, input logic done, input logic rs,
                      input logic push, input logic [7:0] pb);
    logic drop;
    logic [7:0] popped;
    drop = 1'b0;
    io_valid = iv; miso = md; rw_done = done; rd_sel = rs;
    checks++;
    if (m_valid !== (exp_q.size() != 0)) begin
      errors++; $display("FAIL m_valid: got %b want %b", m_valid, exp_q.size() != 0);
    end
    checks++;
    if (fifo_count !== CW'(exp_q.size())) begin
      errors++; $display("FAIL fifo_count: got %0d want %0d", fifo_count, exp_q.size());
    end
    if (exp_q.size() != 0) begin
      checks++;
      if (m_data !== exp_q[0]) begin
        errors++; $display("FAIL m_data: got %02h want %02h", m_data, exp_q[0]);
      end
      if (m_ready) begin
        popped = exp_q.pop_front();
        $display("pop data=%02h", popped);
      end
    end
    if (push) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(pb);
      else drop = 1'b1;
    end
    @(posedge sclk); #1;
    if (drop) exp_ovf = 1'b1;
    else if (ovf_clr) exp_ovf = 1'b0;
    checks++;
    if (overflow !== exp_ovf) begin
      errors++; $display("FAIL overflow: got %b want %b", overflow, exp_ovf);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  // Read of tx_bytes plus extra trailing bits; rdy_last raises m_ready on the last byte's final bit.
  task automatic do_read(input int extra, input bit rdy_last, input string tag);
    logic [7:0] cur, xsum;
    logic       rb;
    xsum = 8'h00;
    rb = 1'($urandom_range(0, 1));
    step(1'b1, rb, 1'b0, 1'b1, 1'b0, 8'h00);
    checks++;
    if (partial !== 1'b0) begin
      errors++; $display("FAIL %s partial_at_start: got %b want 0", tag, partial);
    end
    for (int b = 0; b < tx_bytes.size(); b++) begin
      cur = tx_bytes[b];
      xsum = xsum ^ cur;
      for (int i = 7; i >= 0; i--) begin
        if (rdy_last && b == tx_bytes.size() - 1 && i == 0) m_ready = 1'b1;
        step(1'b1, cur[i], 1'b0, 1'b1, (i == 0), cur);
        if (rdy_last) m_ready = 1'b0;
      end
    end
    for (int i = 0; i < extra; i++) begin
      rb = 1'($urandom_range(0, 1));
      step(1'b1, rb, 1'b0, 1'b1, 1'b0, 8'h00);
    end
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    checks++;
    if (partial !== ((extra % 8) != 0)) begin
      errors++; $display("FAIL %s partial: got %b want %b", tag, partial, (extra % 8) != 0);
    end
`ifdef SRAM_RX_CHECKSUM_EN
    checks++;
    if (rx_checksum !== xsum) begin
      errors++; $display("FAIL %s rx_checksum: got %02h want %02h", tag, rx_checksum, xsum);
    end
`endif
    $display("read %s: bytes=%0d extra_bits=%0d xor=%02h", tag, tx_bytes.size(), extra, xsum);
    idle(1);
  endtask

  task automatic drain(input string tag);
    m_ready = 1'b1;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) idle(1);
    idle(1);
    m_ready = 1'b0;
    checks++;
    if (fifo_count !== '0 || m_valid !== 1'b0) begin
      errors++; $display("FAIL %s drain: count=%0d valid=%b want 0/0", tag, fifo_count, m_valid);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (m_data !== 8'h00 || m_valid !== 1'b0 || fifo_count !== '0 ||
        overflow !== 1'b0 || partial !== 1'b0) begin
      errors++;
      $display("FAIL %s: m_data=%02h m_valid=%b count=%0d ovf=%b partial=%b want all 0",
               tag, m_data, m_valid, fifo_count, overflow, partial);
    end
`ifdef SRAM_RX_CHECKSUM_EN
    checks++;
    if (rx_checksum !== 8'h00) begin
      errors++; $display("FAIL %s rx_checksum: got %02h want 00", tag, rx_checksum);
    end
`endif
    $display("reset %s checked", tag);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge sclk);
    #1;
    check_reset_outputs("power_on");
    rst_n = 1'b1;
    exp_q.delete();
    exp_ovf = 1'b0;
    idle(1);
  endtask

  task automatic test_two_bytes();
    tx_bytes = '{8'hA5, 8'h3C};
    do_read(0, 1'b0, "t1");
    checks++;
    if (fifo_count !== CW'(2)) begin
      errors++; $display("FAIL t1 count_before_drain: got %0d want 2", fifo_count);
    end
    drain("t1");
  endtask

  task automatic test_partial();
    tx_bytes = '{8'h81, 8'h7E};
    do_read(2, 1'b0, "t2");
    tx_bytes = '{8'h5A};
    do_read(0, 1'b0, "t2_next");
    drain("t2");
  endtask

  task automatic test_overflow();
    tx_bytes.delete();
    for (int i = 0; i < 17; i++) tx_bytes.push_back(8'($urandom_range(0, 255)));
    do_read(0, 1'b0, "t3");
    checks++;
    if (overflow !== 1'b1 || fifo_count !== CW'(DEPTH)) begin
      errors++; $display("FAIL t3 full: ovf=%b count=%0d want 1/%0d", overflow, fifo_count, DEPTH);
    end
    ovf_clr = 1'b1;
    idle(1);
    ovf_clr = 1'b0;
    drain("t3");
  endtask

  task automatic test_full_pop();
    tx_bytes.delete();
    for (int i = 0; i < 17; i++) tx_bytes.push_back(8'(8'h10 + i));
    do_read(0, 1'b1, "t4");
    checks++;
    if (overflow !== 1'b0 || fifo_count !== CW'(DEPTH)) begin
      errors++; $display("FAIL t4 full_pop: ovf=%b count=%0d want 0/%0d", overflow, fifo_count, DEPTH);
    end
    drain("t4");
  endtask

  task automatic test_write();
    logic rb;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 39; i++) begin
      rb = 1'($urandom_range(0, 1));
      step(1'b1, rb, 1'b0, 1'b0, 1'b0, 8'h00);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    idle(2);
    $display("write t5: 40 io_valid cycles ignored");
  endtask

  task automatic test_reset_mid();
    logic [7:0] b0, b1;
    b0 = 8'hC3; b1 = 8'h96;
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    for (int i = 7; i >= 0; i--) step(1'b1, b0[i], 1'b0, 1'b1, (i == 0), b0);
    for (int i = 7; i >= 4; i--) step(1'b1, b1[i], 1'b0, 1'b1, 1'b0, b1);
    rst_n = 1'b0;
    @(posedge sclk); #1;
    io_valid = 1'b0;
    @(posedge sclk); #1;
    check_reset_outputs("t6_mid_read");
    rst_n = 1'b1;
    exp_q.delete();
    exp_ovf = 1'b0;
    idle(1);
    tx_bytes = '{8'hFF};
    do_read(0, 1'b0, "t6");
    checks++;
    if (m_data !== 8'hFF) begin
      errors++; $display("FAIL t6 m_data: got %02h want ff", m_data);
    end
    drain("t6");
  endtask

  initial begin
    test_reset();
    test_two_bytes();
    test_partial();
    test_overflow();
    test_full_pop();
    test_write();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
